// File: rtl/pipe_execute.sv
// pipe_execute: execute stage of a Y86-style pipeline with ALU, condition codes and E/M register
// Ports: clk, rst (async, active-high); d_* decode-stage inputs; e_stall holds all state,
// e_bubble loads a NOP; set_cc_en permits CC update; m_* registered results; cc = {OF,SF,ZF}.
module pipe_execute #(
  parameter int WIDTH = 64,
  parameter int STEP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [WIDTH-1:0] d_valA,
  input  logic [WIDTH-1:0] d_valB,
  input  logic [WIDTH-1:0] d_valC,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic             e_stall,
  input  logic             e_bubble,
  input  logic             set_cc_en,
  output logic [3:0]       m_icode,
  output logic [WIDTH-1:0] m_valE,
  output logic [WIDTH-1:0] m_valA,
  output logic [3:0]       m_dstE,
  output logic [3:0]       m_dstM,
  output logic             m_cnd,
  output logic [2:0]       cc
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam int M = WIDTH - 1;
  logic [WIDTH-1:0] op_res, val_e;
  logic             of, sf, zf, cond, cnd, set_cc, op_of;
  logic [3:0]       dst_e;
  always_comb begin
    op_res = d_ifun == 4'h0 ? d_valB + d_valA :
             d_ifun == 4'h1 ? d_valB - d_valA :
             d_ifun == 4'h2 ? d_valA & d_valB :
             d_ifun == 4'h3 ? d_valA ^ d_valB : '0;
    val_e = d_icode == 4'h3 ? d_valC :
            (d_icode == 4'h4 || d_icode == 4'h5) ? d_valB + d_valC :
            d_icode == 4'h6 ? op_res :
            (d_icode == 4'h8 || d_icode == 4'hA) ? d_valB - STEP_W :
            (d_icode == 4'h9 || d_icode == 4'hB) ? d_valB + STEP_W :
            d_icode == 4'h2 ? d_valA : '0;
    op_of = d_ifun == 4'h0 ? (d_valA[M] == d_valB[M]) && (op_res[M] != d_valA[M]) :
            d_ifun == 4'h1 ? (d_valA[M] != d_valB[M]) && (op_res[M] != d_valB[M]) : 1'b0;
    // conditions read the registered flags, so a preceding OPq is already visible here
    {of, sf, zf} = cc;
    cond = d_ifun == 4'h0 ? 1'b1 :
           d_ifun == 4'h1 ? (sf ^ of) | zf :
           d_ifun == 4'h2 ? sf ^ of :
           d_ifun == 4'h3 ? zf :
           d_ifun == 4'h4 ? ~zf :
           d_ifun == 4'h5 ? ~(sf ^ of) :
           d_ifun == 4'h6 ? ~(sf ^ of) & ~zf : 1'b0;
    cnd = (d_icode == 4'h2 || d_icode == 4'h7) ? cond : 1'b0;
    dst_e = (d_icode == 4'h2 && !cnd) ? 4'hF : d_dstE;
    set_cc = d_icode == 4'h6 && d_ifun <= 4'h3 && set_cc_en;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_icode <= 4'h1;
      m_valE  <= '0;
      m_valA  <= '0;
      m_dstE  <= 4'hF;
      m_dstM  <= 4'hF;
      m_cnd   <= 1'b0;
      cc      <= 3'b001;
    end else if (!e_stall) begin
      m_icode <= e_bubble ? 4'h1 : d_icode;
      m_valE  <= e_bubble ? '0 : val_e;
      m_valA  <= e_bubble ? '0 : d_valA;
      m_dstE  <= e_bubble ? 4'hF : dst_e;
      m_dstM  <= e_bubble ? 4'hF : d_dstM;
      m_cnd   <= e_bubble ? 1'b0 : cnd;
      if (!e_bubble && set_cc) cc <= {op_of, op_res[M], op_res == '0};
    end
  end
endmodule

// File: tb/tb_pipe_execute.sv
// tb_pipe_execute: directed self-checking bench for pipe_execute (WIDTH=64, STEP=8)
module tb_pipe_execute;
  logic        clk = 1'b0, rst = 1'b0;
  logic [3:0]  d_icode = 4'h1, d_ifun = 4'h0, d_dstE = 4'hF, d_dstM = 4'hF;
  logic [63:0] d_valA = '0, d_valB = '0, d_valC = '0;
  logic        e_stall = 1'b0, e_bubble = 1'b0, set_cc_en = 1'b1;
  logic [3:0]  m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valA;
  logic        m_cnd;
  logic [2:0]  cc;
  int checks = 0, errors = 0;

  pipe_execute #(.WIDTH(64), .STEP(8)) dut (
    .clk(clk), .rst(rst), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .e_stall(e_stall), .e_bubble(e_bubble),
    .set_cc_en(set_cc_en), .m_icode(m_icode), .m_valE(m_valE), .m_valA(m_valA),
    .m_dstE(m_dstE), .m_dstM(m_dstM), .m_cnd(m_cnd), .cc(cc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                      input logic [3:0] dm, input logic st, input logic bb, input logic sc);
    @(negedge clk);
    d_icode = ic; d_ifun = fn; d_valA = a; d_valB = b; d_valC = c;
    d_dstE = de; d_dstM = dm; e_stall = st; e_bubble = bb; set_cc_en = sc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_icode"}, 64'(m_icode), 64'h1);
    chk({tag, "_dstE"}, 64'(m_dstE), 64'hF);
    chk({tag, "_dstM"}, 64'(m_dstM), 64'hF);
    chk({tag, "_valE"}, m_valE, 64'h0);
    chk({tag, "_valA"}, m_valA, 64'h0);
    chk({tag, "_cnd"}, 64'(m_cnd), 64'h0);
    chk({tag, "_cc"}, 64'(cc), 64'h1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 chk_reset("rst0");
    @(negedge clk) rst = 1'b0;
    step(4'h6, 4'h1, 64'd5, 64'd5, 0, 4'h2, 4'hF, 0, 0, 1);
    chk("sub_valE", m_valE, 64'h0);
    chk("sub_cc", 64'(cc), 64'h1);
    chk("sub_dstE", 64'(m_dstE), 64'h2);
    chk("sub_valA", m_valA, 64'h5);
    step(4'h7, 4'h3, 0, 0, 0, 4'hF, 4'hF, 0, 0, 1);
    chk("je_cnd", 64'(m_cnd), 64'h1);
    step(4'h2, 4'h4, 64'h1234, 0, 0, 4'h3, 4'hF, 0, 0, 1);
    chk("cmovne_cnd", 64'(m_cnd), 64'h0);
    chk("cmovne_dstE", 64'(m_dstE), 64'hF);
    chk("cmovne_valE", m_valE, 64'h1234);
    step(4'h6, 4'h0, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 0, 4'h1, 4'hF, 0, 0, 1);
    chk("addov_valE", m_valE, 64'h8000_0000_0000_0000);
    chk("addov_cc", 64'(cc), 64'h6);
    step(4'h7, 4'h6, 0, 0, 0, 4'hF, 4'hF, 0, 0, 1);
    chk("jg_cnd", 64'(m_cnd), 64'h1);
    step(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF, 0, 0, 1);
    chk("jl_cnd", 64'(m_cnd), 64'h0);
    step(4'hA, 4'h0, 0, 64'h100, 0, 4'h4, 4'hF, 0, 0, 1);
    chk("push_valE", m_valE, 64'hF8);
    chk("push_cc", 64'(cc), 64'h6);
    chk("push_cnd", 64'(m_cnd), 64'h0);
    step(4'hB, 4'h0, 0, 64'hF8, 0, 4'h4, 4'h7, 0, 0, 1);
    chk("pop_valE", m_valE, 64'h100);
    chk("pop_dstM", 64'(m_dstM), 64'h7);
    chk("pop_cc", 64'(cc), 64'h6);
    step(4'h3, 4'h0, 0, 0, 64'h55, 4'h2, 4'hF, 0, 0, 1);
    chk("irmov_valE", m_valE, 64'h55);
    step(4'h5, 4'h0, 0, 64'h10, 64'h8, 4'hF, 4'h3, 0, 0, 1);
    chk("mrmov_valE", m_valE, 64'h18);
    step(4'h6, 4'h2, 64'hF0, 64'h0F, 0, 4'h1, 4'hF, 0, 0, 1);
    chk("and_valE", m_valE, 64'h0);
    chk("and_cc", 64'(cc), 64'h1);
    step(4'h6, 4'h3, 64'hF0, 64'hFF, 0, 4'h1, 4'hF, 0, 0, 1);
    chk("xor_valE", m_valE, 64'h0F);
    chk("xor_cc", 64'(cc), 64'h0);
    step(4'h6, 4'h1, 64'h1, 64'h0, 0, 4'h1, 4'hF, 0, 0, 1);
    chk("subneg_valE", m_valE, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("subneg_cc", 64'(cc), 64'h2);
    step(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 0, 4'h1, 4'hF, 0, 0, 1);
    chk("subov_valE", m_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("subov_cc", 64'(cc), 64'h4);
    step(4'h6, 4'h4, 64'h3, 64'h3, 0, 4'h1, 4'hF, 0, 0, 1);
    chk("opbad_valE", m_valE, 64'h0);
    chk("opbad_cc", 64'(cc), 64'h4);
    step(4'h6, 4'h0, 64'h1, 64'h2, 0, 4'h5, 4'h6, 1, 0, 1);
    chk("stall_icode", 64'(m_icode), 64'h6);
    chk("stall_valE", m_valE, 64'h0);
    chk("stall_valA", m_valA, 64'h3);
    chk("stall_dstE", 64'(m_dstE), 64'h1);
    chk("stall_cc", 64'(cc), 64'h4);
    step(4'h6, 4'h0, 64'h1, 64'h2, 0, 4'h5, 4'h6, 0, 0, 0);
    chk("noccen_valE", m_valE, 64'h3);
    chk("noccen_cc", 64'(cc), 64'h4);
    step(4'h6, 4'h0, 64'h1, 64'h2, 0, 4'h5, 4'h6, 0, 1, 1);
    chk("bubble_icode", 64'(m_icode), 64'h1);
    chk("bubble_dstE", 64'(m_dstE), 64'hF);
    chk("bubble_dstM", 64'(m_dstM), 64'hF);
    chk("bubble_valE", m_valE, 64'h0);
    chk("bubble_cc", 64'(cc), 64'h4);
    step(4'h2, 4'h0, 64'h9, 0, 0, 4'h5, 4'hF, 0, 0, 1);
    chk("rrmov_cnd", 64'(m_cnd), 64'h1);
    chk("rrmov_dstE", 64'(m_dstE), 64'h5);
    step(4'h6, 4'h0, 64'h7, 64'h8, 0, 4'h2, 4'hF, 0, 0, 1);
    chk("add_cc_pre", 64'(cc), 64'h0);
    #2 rst = 1'b1;
    #1 chk_reset("rstmid");
    e_stall = 1'b1;
    e_bubble = 1'b1;
    @(negedge clk) rst = 1'b0;
    step(4'h3, 4'h0, 64'h2, 0, 64'h77, 4'h4, 4'hF, 0, 0, 1);
    chk("post_rst_valE", m_valE, 64'h77);
    chk("post_rst_icode", 64'(m_icode), 64'h3);
    chk("post_rst_dstE", 64'(m_dstE), 64'h4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
